// File: rtl/que_grant_encode.sv
// Registers a winning index into a one-hot grant held until done/MAX_HOLD, then an idle gap.
// Latency 1 cycle accept->grant; o_sel_rdy only in IDLE, so i_sel_vld is ignored while busy.
module que_grant_encode #(
    parameter  int NUM_PORT = 9,
    parameter  int MAX_HOLD = 64,
    parameter  int GAP      = 1,
    localparam int IDX_W    = $clog2(NUM_PORT)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_sel_vld,
    input  logic [IDX_W-1:0]    i_sel,
    output logic                o_sel_rdy,
    output logic [NUM_PORT-1:0] o_gnt,
    output logic [IDX_W-1:0]    o_gnt_idx,
    input  logic [NUM_PORT-1:0] i_done,
    output logic                o_busy,
    output logic                o_timeout,
    output logic                o_err
);

    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam int GAP_W  = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_GAP
    } state_t;

    state_t              r_state,    w_state_nxt;
    logic [NUM_PORT-1:0] r_gnt,      w_gnt_nxt;
    logic [IDX_W-1:0]    r_gnt_idx,  w_gnt_idx_nxt;
    logic [HOLD_W-1:0]   r_hold_cnt, w_hold_cnt_nxt;
    logic [GAP_W-1:0]    r_gap_cnt,  w_gap_cnt_nxt;
    logic                r_timeout,  w_timeout_nxt;
    logic                r_err,      w_err_nxt;

    logic w_accept;
    logic w_sel_ok;
    logic w_done;
    logic w_hold_last;
    logic w_gap_last;

    assign o_sel_rdy = (r_state == ST_IDLE) & ~i_rst;
    assign w_accept  = i_sel_vld & o_sel_rdy;
    assign w_sel_ok  = {{(32-IDX_W){1'b0}}, i_sel} < 32'(NUM_PORT);

    // r_gnt is one-hot, so masking picks out exactly the granted port's done bit
    assign w_done      = |(i_done & r_gnt);
    assign w_hold_last = (r_hold_cnt == HOLD_W'(MAX_HOLD - 1));
    assign w_gap_last  = (r_gap_cnt == GAP_W'((GAP > 0) ? GAP - 1 : 0));

    always_comb begin
        w_state_nxt    = r_state;
        w_gnt_nxt      = r_gnt;
        w_gnt_idx_nxt  = r_gnt_idx;
        w_hold_cnt_nxt = r_hold_cnt;
        w_gap_cnt_nxt  = r_gap_cnt;
        w_timeout_nxt  = 1'b0;
        w_err_nxt      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_sel_ok) begin
                        w_state_nxt    = ST_GRANT;
                        w_gnt_nxt      = NUM_PORT'(1) << i_sel;
                        w_gnt_idx_nxt  = i_sel;
                        w_hold_cnt_nxt = '0;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            ST_GRANT: begin
                if (w_done || w_hold_last) begin
                    w_state_nxt    = (GAP > 0) ? ST_GAP : ST_IDLE;
                    w_gnt_nxt      = '0;
                    w_gnt_idx_nxt  = '0;
                    w_hold_cnt_nxt = '0;
                    w_gap_cnt_nxt  = '0;
                    w_timeout_nxt  = ~w_done;
                end else if (r_hold_cnt != {HOLD_W{1'b1}}) begin
                    w_hold_cnt_nxt = r_hold_cnt + HOLD_W'(1);
                end
            end
            ST_GAP: begin
                if (w_gap_last) begin
                    w_state_nxt   = ST_IDLE;
                    w_gap_cnt_nxt = '0;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + GAP_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_gnt      <= '0;
            r_gnt_idx  <= '0;
            r_hold_cnt <= '0;
            r_gap_cnt  <= '0;
            r_timeout  <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt      <= w_gnt_nxt;
            r_gnt_idx  <= w_gnt_idx_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
            r_gap_cnt  <= w_gap_cnt_nxt;
            r_timeout  <= w_timeout_nxt;
            r_err      <= w_err_nxt;
        end
    end

    assign o_gnt     = r_gnt;
    assign o_gnt_idx = r_gnt_idx;
    assign o_busy    = (r_state != ST_IDLE);
    assign o_timeout = r_timeout;
    assign o_err     = r_err;

endmodule
